clint_timer: RTL and testbench

Memory-mapped machine timer that produces the clock interrupt request consumed by the interrupt manager. It holds a free-running 64-bit `mtime`, a 64-bit `mtimecmp` and a small control register, and drives `irq_timer` onto `irq_pins[CLOCK_IRQ_PIN]`. Software reprograms `mtimecmp` inside the trap handler to acknowledge the interrupt. It sits on the data-memory bus beside RAM and the other peripherals, selected by the bus address decoder.

---
 rtl/clint_timer.sv | 123 ++++++++++++
 tb/tb_clint_timer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clint_timer.sv
// Memory-mapped machine timer: 64-bit mtime with prescaler, 64-bit mtimecmp, level timer IRQ.
// Optional macro TIMER_HI_LATCH_EN: mtime_lo reads snapshot mtime[63:32] for an atomic 64-bit read.
module clint_timer #(
   parameter int unsigned CLK_DIV = 1
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        sel,
   input  logic        we,
   input  logic        re,
   input  logic [4:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq_timer
);

   typedef enum logic [2:0] {
      REG_MTIME_LO = 3'd0,
      REG_MTIME_HI = 3'd1,
      REG_CMP_LO   = 3'd2,
      REG_CMP_HI   = 3'd3,
      REG_CTRL     = 3'd4,
      REG_STATUS   = 3'd5
   } reg_e;

   localparam logic [15:0] PRE_LAST = 16'(CLK_DIV - 1);

   logic [63:0] mtime;
   logic [63:0] mtimecmp;
   logic [15:0] pre;
   logic        run;
   logic        irq_en;
   logic        wr;
   logic        rd;
   logic        wr_mtime;
   logic        match;
   reg_e        idx;
   logic [31:0] rmux;
`ifdef TIMER_HI_LATCH_EN
   logic [31:0] hi_shadow;
`endif

   assign idx      = reg_e'(addr[4:2]);
   assign wr       = sel & we;
   assign rd       = sel & re;
   assign wr_mtime = wr && (idx == REG_MTIME_LO || idx == REG_MTIME_HI);
   assign match    = mtime >= mtimecmp;

   // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
   always_comb begin
      rmux = '0;
      case (idx)
         REG_MTIME_LO: rmux = mtime[31:0];
`ifdef TIMER_HI_LATCH_EN
         REG_MTIME_HI: rmux = hi_shadow;
`else
         REG_MTIME_HI: rmux = mtime[63:32];
`endif
         REG_CMP_LO:   rmux = mtimecmp[31:0];
         REG_CMP_HI:   rmux = mtimecmp[63:32];
         REG_CTRL:     rmux = {30'd0, irq_en, run};
         REG_STATUS:   rmux = {31'd0, match};
         default:      rmux = '0;
      endcase
   end

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values, as the hardware does.
   // A software write to either mtime word suppresses that cycle's increment and restarts the prescaler.
   always_ff @(posedge clk) begin
      if (clr) begin
         mtime <= '0;
         pre   <= '0;
      end else if (wr_mtime) begin
         if (idx == REG_MTIME_LO) mtime[31:0]  <= wdata;
         else                     mtime[63:32] <= wdata;
         pre <= '0;
      end else if (run) begin
         if (pre == PRE_LAST) begin
            pre   <= '0;
            mtime <= mtime + 64'd1;
         end else begin
            pre <= pre + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         mtimecmp <= '1;
         run      <= 1'b0;
         irq_en   <= 1'b0;
      end else if (wr) begin
         case (idx)
            REG_CMP_LO: mtimecmp[31:0]  <= wdata;
            REG_CMP_HI: mtimecmp[63:32] <= wdata;
            REG_CTRL: begin
               run    <= wdata[0];
               irq_en <= wdata[1];
            end
            default: ;
         endcase
      end
   end

   // Read data and interrupt are registered from pre-write state, so a combined read/write returns old data.
   always_ff @(posedge clk) begin
      if (clr) begin
         rdata     <= '0;
         irq_timer <= 1'b0;
      end else begin
         irq_timer <= irq_en & match;
         if (rd) rdata <= rmux;
      end
   end

`ifdef TIMER_HI_LATCH_EN
   always_ff @(posedge clk) begin
      if (clr)                            hi_shadow <= '0;
      else if (rd && idx == REG_MTIME_LO) hi_shadow <= mtime[63:32];
   end
`endif

endmodule

// File: tb/tb_clint_timer.sv
// Self-checking bench for clint_timer: two instances (CLK_DIV 1 and 4) against a tick-count model.
// Honours TIMER_HI_LATCH_EN the same way the design does.
module tb_clint_timer;

`ifdef TIMER_HI_LATCH_EN
   localparam bit LATCH = 1'b1;
`else
   localparam bit LATCH = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        clr;
   logic        sel;
   logic        we;
   logic        re;
   logic [4:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata1, rdata4;
   logic        irq1, irq4;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   clint_timer #(.CLK_DIV(1)) dut1 (
      .clk(clk), .clr(clr), .sel(sel), .we(we), .re(re),
      .addr(addr), .wdata(wdata), .rdata(rdata1), .irq_timer(irq1)
   );

   clint_timer #(.CLK_DIV(4)) dut4 (
      .clk(clk), .clr(clr), .sel(sel), .we(we), .re(re),
      .addr(addr), .wdata(wdata), .rdata(rdata4), .irq_timer(irq4)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      else passed++;
   endtask

   // Model: mtime = value at last software write (or reset) + completed prescaler periods since then.
   logic [63:0]     m_base[2];
   longint unsigned m_cnt[2];
   logic [31:0]     m_shadow[2];
   logic [31:0]     m_rdata[2];
   logic            m_irq[2];
   logic [63:0]     m_cmp;
   logic            m_run;
   logic            m_ien;
   bit              m_valid = 1'b0;

   function automatic longint unsigned div_of(int i);
      return (i == 0) ? 64'd1 : 64'd4;
   endfunction

   function automatic logic [63:0] m_time(int i);
      return m_base[i] + 64'(m_cnt[i] / div_of(i));
   endfunction

   function automatic logic [31:0] m_lo(int i);
      logic [63:0] t;
      t = m_time(i);
      return t[31:0];
   endfunction

   function automatic logic [31:0] m_hi(int i);
      logic [63:0] t;
      t = m_time(i);
      return t[63:32];
   endfunction

   function automatic logic [31:0] m_read(int i, logic [4:0] a);
      case (a[4:2])
         3'd0: return m_lo(i);
         3'd1: return LATCH ? m_shadow[i] : m_hi(i);
         3'd2: return m_cmp[31:0];
         3'd3: return m_cmp[63:32];
         3'd4: return {30'd0, m_ien, m_run};
         3'd5: return {31'd0, m_time(i) >= m_cmp};
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge clk) begin
      if (clr) begin
         m_valid <= 1'b1;
         m_cmp   <= '1;
         m_run   <= 1'b0;
         m_ien   <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            m_base[i]   <= '0;
            m_cnt[i]    <= 0;
            m_shadow[i] <= '0;
            m_rdata[i]  <= '0;
            m_irq[i]    <= 1'b0;
         end
      end else if (m_valid) begin
         for (int i = 0; i < 2; i++) begin
            m_irq[i] <= m_ien && (m_time(i) >= m_cmp);
            if (sel && re) begin
               m_rdata[i] <= m_read(i, addr);
               if (LATCH && addr[4:2] == 3'd0) m_shadow[i] <= m_hi(i);
            end
            if (sel && we && addr[4:2] == 3'd0) begin
               m_base[i] <= {m_hi(i), wdata};
               m_cnt[i]  <= 0;
            end else if (sel && we && addr[4:2] == 3'd1) begin
               m_base[i] <= {wdata, m_lo(i)};
               m_cnt[i]  <= 0;
            end else if (m_run) begin
               m_cnt[i] <= m_cnt[i] + 1;
            end
         end
         if (sel && we) begin
            case (addr[4:2])
               3'd2: m_cmp[31:0]  <= wdata;
               3'd3: m_cmp[63:32] <= wdata;
               3'd4: begin
                  m_run <= wdata[0];
                  m_ien <= wdata[1];
               end
               default: ;
            endcase
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("rdata_div1", rdata1, m_rdata[0]);
         check("irq_div1", {31'd0, irq1}, {31'd0, m_irq[0]});
         check("rdata_div4", rdata4, m_rdata[1]);
         check("irq_div4", {31'd0, irq4}, {31'd0, m_irq[1]});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
      sel = 1'b1; we = 1'b1; re = 1'b0; addr = a; wdata = d;
      step();
      sel = 1'b0; we = 1'b0;
   endtask

   task automatic bus_read(input logic [4:0] a);
      sel = 1'b1; we = 1'b0; re = 1'b1; addr = a;
      step();
      sel = 1'b0; re = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      bus_read(5'h08); check({tag, "_cmp_lo"}, rdata1, 32'hFFFF_FFFF);
      bus_read(5'h0C); check({tag, "_cmp_hi"}, rdata1, 32'hFFFF_FFFF);
      bus_read(5'h00); check({tag, "_mtime_lo"}, rdata1, 32'd0);
      bus_read(5'h04); check({tag, "_mtime_hi"}, rdata1, 32'd0);
      bus_read(5'h10); check({tag, "_ctrl"}, rdata1, 32'd0);
      bus_read(5'h14); check({tag, "_status"}, rdata1, 32'd0);
      check({tag, "_irq"}, {31'd0, irq1}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clr = 1'b1; sel = 1'b0; we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
      step();
      step();
      clr = 1'b0;

      check_reset_state("reset");

      // Prescaler: 40 running cycles give 40 ticks at div 1 and 10 at div 4.
      bus_write(5'h10, 32'd1);
      repeat (40) step();
      bus_read(5'h00);
      check("presc_div4", rdata4, 32'd10);
      check("presc_div1", rdata1, 32'd40);

      // Interrupt rise and fall at div 1.
      bus_write(5'h10, 32'd0);
      bus_write(5'h00, 32'd0);
      bus_write(5'h04, 32'd0);
      bus_write(5'h08, 32'd20);
      bus_write(5'h0C, 32'd0);
      bus_write(5'h10, 32'd3);
      repeat (20) step();
      check("irq_before_match", {31'd0, irq1}, 32'd0);
      step();
      check("irq_rise", {31'd0, irq1}, 32'd1);
      check("irq_div4_low", {31'd0, irq4}, 32'd0);
      bus_write(5'h08, 32'd1000);
      check("irq_hold_on_write", {31'd0, irq1}, 32'd1);
      step();
      check("irq_fall", {31'd0, irq1}, 32'd0);

      // 64-bit wrap after two increments.
      bus_write(5'h10, 32'd0);
      bus_write(5'h04, 32'hFFFF_FFFF);
      bus_write(5'h00, 32'hFFFF_FFFE);
      bus_write(5'h10, 32'd1);
      step();
      bus_write(5'h10, 32'd0);
      bus_read(5'h00); check("wrap_lo", rdata1, 32'd0);
      bus_read(5'h04); check("wrap_hi", rdata1, 32'd0);

      // Carry from low to high word.
      bus_write(5'h04, 32'd5);
      bus_write(5'h00, 32'hFFFF_FFFF);
      bus_write(5'h10, 32'd1);
      bus_write(5'h10, 32'd0);
      bus_read(5'h04); check("carry_hi", rdata1, 32'd6);
      bus_read(5'h00); check("carry_lo", rdata1, 32'd0);

      // A write to mtime_lo wins over a due increment.
      bus_write(5'h10, 32'd1);
      bus_write(5'h00, 32'h0000_1234);
      bus_read(5'h00);
      check("prio_div1", rdata1, 32'h0000_1234);
      check("prio_div4", rdata4, 32'h0000_1234);
      bus_write(5'h10, 32'd0);

      // Simultaneous read and write returns the old value; unselected write is ignored.
      sel = 1'b1; we = 1'b1; re = 1'b1; addr = 5'h08; wdata = 32'h55;
      step();
      sel = 1'b0; we = 1'b0; re = 1'b0;
      check("rw_old_value", rdata1, 32'd1000);
      bus_read(5'h08); check("rw_new_value", rdata1, 32'h55);
      sel = 1'b0; we = 1'b1; addr = 5'h08; wdata = 32'h77;
      step();
      we = 1'b0;
      bus_read(5'h08); check("unselected_write", rdata1, 32'h55);

      // Reset overrides a simultaneous write while running.
      bus_write(5'h10, 32'd3);
      clr = 1'b1; sel = 1'b1; we = 1'b1; addr = 5'h00; wdata = 32'hABCD;
      step();
      clr = 1'b0; sel = 1'b0; we = 1'b0;
      check_reset_state("clr_write");

      // High-word read across a low-word rollover.
      bus_write(5'h04, 32'd1);
      bus_write(5'h00, 32'hFFFF_FFF0);
      bus_write(5'h10, 32'd1);
      bus_read(5'h00); check("latch_lo", rdata1, 32'hFFFF_FFF0);
      repeat (20) step();
      bus_read(5'h04); check("latch_hi", rdata1, LATCH ? 32'd1 : 32'd2);
      bus_write(5'h10, 32'd0);

      // Randomized traffic, checked every cycle by the compare process.
      for (int n = 0; n < 2000; n++) begin
         clr   = ($urandom_range(0, 199) == 0);
         sel   = ($urandom_range(0, 3) != 0);
         we    = $urandom_range(0, 1) == 1;
         re    = $urandom_range(0, 1) == 1;
         addr  = 5'($urandom_range(0, 31));
         wdata = $urandom_range(0, 1) == 1 ? $urandom() : 32'($urandom_range(0, 64));
         step();
      end
      clr = 1'b0; sel = 1'b0; we = 1'b0; re = 1'b0;
      step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
